// File: rtl/mem_access_if.sv
// Data-bus port bundle for the MEM stage: word-aligned request/ack bus.
// master: drives req/we/addr/sel/wdata; slave: returns rdata/ack.
interface mem_access_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_access.sv
// MEM stage: passes EX/MEM fields to MEM/WB and runs load/store bus cycles.
// Ports: clk, rst (async active-low), ex_* in, mem_* out, bus (master), stall_req, align_err.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ex_inst,
   input  logic [4:0]  ex_waddr,
   input  logic        ex_reg_we,
   input  logic [31:0] ex_data,
   input  logic [3:0]  ex_mem_op,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_store_data,
   input  logic        ex_hi_we,
   input  logic        ex_lo_we,
   input  logic [31:0] ex_hi,
   input  logic [31:0] ex_lo,
   output logic [31:0] mem_inst,
   output logic [4:0]  mem_waddr,
   output logic        mem_reg_we,
   output logic [31:0] mem_data,
   output logic        mem_hi_we,
   output logic        mem_lo_we,
   output logic [31:0] mem_hi,
   output logic [31:0] mem_lo,
   mem_access_if.master bus,
   output logic        stall_req,
   output logic        align_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   state_t      state_q, state_d;
   logic        req_q, we_q;
   logic [31:0] addr_q, wdata_q, res_q;
   logic [3:0]  sel_q, op_q;
   logic [1:0]  off_q;

   logic        is_byte, is_half, is_word;
   logic        is_store, is_mem, misalign, op_q_store;
   logic [3:0]  sel_d;
   logic [31:0] wdata_d, ld_val;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      is_byte  = (ex_mem_op == OP_LB) || (ex_mem_op == OP_LBU)
              || (ex_mem_op == OP_SB);
      is_half  = (ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU)
              || (ex_mem_op == OP_SH);
      is_word  = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
      is_store = (ex_mem_op == OP_SB) || (ex_mem_op == OP_SH)
              || (ex_mem_op == OP_SW);
      is_mem   = is_byte || is_half || is_word;
      misalign = (is_half && ex_mem_addr[0])
              || (is_word && (ex_mem_addr[1:0] != 2'b00));
      op_q_store = (op_q == OP_SB) || (op_q == OP_SH)
                || (op_q == OP_SW);
   end

   // Byte enables and lane-replicated store data for the request.
   always_comb begin
      sel_d   = 4'b0000;
      wdata_d = ex_store_data;
      unique case (1'b1)
         is_byte: begin
            sel_d   = 4'b0001 << ex_mem_addr[1:0];
            wdata_d = {4{ex_store_data[7:0]}};
         end
         is_half: begin
            sel_d   = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{ex_store_data[15:0]}};
         end
         is_word: sel_d = 4'b1111;
         default: ;
      endcase
   end

   // Lane select and extension of the returned word.
   always_comb begin
      byte_v = bus.bus_rdata[{off_q, 3'b000} +: 8];
      half_v = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      unique case (op_q)
         OP_LB:   ld_val = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  ld_val = {24'h0, byte_v};
         OP_LH:   ld_val = {{16{half_v[15]}}, half_v};
         OP_LHU:  ld_val = {16'h0, half_v};
         default: ld_val = bus.bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
         res_q   <= '0;
         op_q    <= '0;
         off_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (is_mem && !misalign) begin
               req_q   <= 1'b1;
               we_q    <= is_store;
               addr_q  <= {ex_mem_addr[31:2], 2'b00};
               sel_q   <= sel_d;
               wdata_q <= wdata_d;
               op_q    <= ex_mem_op;
               off_q   <= ex_mem_addr[1:0];
            end
            BUSY: if (bus.bus_ack) begin
               req_q <= 1'b0;
               res_q <= ld_val;
            end
            default: ;
         endcase
      end
   end

   // Register writes are suppressed until the access completes in DONE.
   always_comb begin
      state_d    = state_q;
      mem_inst   = ex_inst;
      mem_waddr  = ex_waddr;
      mem_reg_we = ex_reg_we;
      mem_data   = ex_data;
      mem_hi_we  = ex_hi_we;
      mem_lo_we  = ex_lo_we;
      mem_hi     = ex_hi;
      mem_lo     = ex_lo;
      stall_req  = 1'b0;
      align_err  = 1'b0;
      unique case (state_q)
         IDLE: if (is_mem) begin
            mem_reg_we = 1'b0;
            if (misalign) begin
               align_err = 1'b1;
            end else begin
               stall_req = 1'b1;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            mem_reg_we = 1'b0;
            stall_req  = 1'b1;
            if (bus.bus_ack) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
            if (op_q_store) mem_reg_we = 1'b0;
            else            mem_data   = res_q;
         end
         default: state_d = IDLE;
      endcase
      if (!rst) begin
         mem_inst   = '0;
         mem_waddr  = '0;
         mem_reg_we = 1'b0;
         mem_data   = '0;
         mem_hi_we  = 1'b0;
         mem_lo_we  = 1'b0;
         mem_hi     = '0;
         mem_lo     = '0;
         stall_req  = 1'b0;
         align_err  = 1'b0;
      end
   end

   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_sel   = sel_q;
   assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed and random load/store
// transactions checked against a queue of expected bus/result values.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ex_inst, ex_data, ex_mem_addr, ex_store_data;
   logic [31:0] ex_hi, ex_lo;
   logic [4:0]  ex_waddr;
   logic        ex_reg_we, ex_hi_we, ex_lo_we;
   logic [3:0]  ex_mem_op;
   logic [31:0] mem_inst, mem_data, mem_hi, mem_lo;
   logic [4:0]  mem_waddr;
   logic        mem_reg_we, mem_hi_we, mem_lo_we;
   logic        stall_req, align_err;

   mem_access_if bus ();

   mem_access dut (
      .clk           (clk),
      .rst           (rst),
      .ex_inst       (ex_inst),
      .ex_waddr      (ex_waddr),
      .ex_reg_we     (ex_reg_we),
      .ex_data       (ex_data),
      .ex_mem_op     (ex_mem_op),
      .ex_mem_addr   (ex_mem_addr),
      .ex_store_data (ex_store_data),
      .ex_hi_we      (ex_hi_we),
      .ex_lo_we      (ex_lo_we),
      .ex_hi         (ex_hi),
      .ex_lo         (ex_lo),
      .mem_inst      (mem_inst),
      .mem_waddr     (mem_waddr),
      .mem_reg_we    (mem_reg_we),
      .mem_data      (mem_data),
      .mem_hi_we     (mem_hi_we),
      .mem_lo_we     (mem_lo_we),
      .mem_hi        (mem_hi),
      .mem_lo        (mem_lo),
      .bus           (bus),
      .stall_req     (stall_req),
      .align_err     (align_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] data;
      logic        rwe;
      int          stalls;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_bad = 0;

   localparam logic [31:0] EXD = 32'hCAFE_F00D;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ld_ref(input logic [3:0] op,
         input logic [1:0] off, input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0: b = rd[7:0];
         2'd1: b = rd[15:8];
         2'd2: b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = off[1] ? rd[31:16] : rd[15:0];
      case (op)
         4'd1: return {{24{b[7]}}, b};
         4'd2: return {24'h0, b};
         4'd3: return {{16{h[15]}}, h};
         4'd4: return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] sel_ref(input logic [3:0] op,
         input logic [1:0] off);
      case (op)
         4'd1, 4'd2, 4'd6: return 4'b0001 << off;
         4'd3, 4'd4, 4'd7: return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // One memory instruction: push expectation, drive, act as bus slave.
   task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
         input logic [31:0] sd, input logic [31:0] rd, input int dly,
         input exp_t e);
      exp_t cur;
      int   stalls = 0;
      int   reqc = 0;
      bit   got_req = 0;
      bit   done = 0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      ex_mem_op     = op;
      ex_mem_addr   = addr;
      ex_store_data = sd;
      ex_data       = EXD;
      ex_reg_we     = 1'b1;
      bus.bus_rdata = rd;
      bus.bus_ack   = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("stall_idle", {31'b0, stall_req}, 1);
            check("req_idle", {31'b0, bus.bus_req}, 0);
            check("rwe_idle", {31'b0, mem_reg_we}, 0);
         end
         if (stall_req) stalls++;
         if (bus.bus_req && !got_req) begin
            got_req = 1;
            cur = exp_q.pop_front();
            check("bus_we", {31'b0, bus.bus_we}, {31'b0, cur.we});
            check("bus_sel", {28'b0, bus.bus_sel}, {28'b0, cur.sel});
            if (cur.we) check("bus_wdata", bus.bus_wdata, cur.wdata);
         end
         if (bus.bus_req) begin
            reqc++;
            check("bus_addr", bus.bus_addr, cur.addr);
            if (reqc > dly) bus.bus_ack = 1'b1;
         end else if (got_req && !stall_req) begin
            check("mem_data", mem_data, cur.data);
            check("mem_rwe", {31'b0, mem_reg_we}, {31'b0, cur.rwe});
            check("stalls", stalls, cur.stalls);
            done = 1;
         end
      end
      if (!done) check("op_timeout", 0, 1);
      @(posedge clk); #1;
      bus.bus_ack = 1'b0;
      ex_mem_op   = 4'd0;
   endtask

   function automatic exp_t mk(input logic we, input logic [31:0] addr,
         input logic [3:0] sel, input logic [31:0] wd,
         input logic [31:0] d, input logic rwe, input int st);
      exp_t e;
      e.we = we; e.addr = addr; e.sel = sel; e.wdata = wd;
      e.data = d; e.rwe = rwe; e.stalls = st;
      return e;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a, rd;
      int          dl;
      rst = 1'b0;
      ex_inst = 32'h0000_0033; ex_waddr = 5'd7; ex_reg_we = 1'b1;
      ex_data = 32'h1234; ex_mem_op = 4'd0; ex_mem_addr = '0;
      ex_store_data = '0; ex_hi_we = 1'b1; ex_lo_we = 1'b1;
      ex_hi = 32'h1111; ex_lo = 32'h2222;
      bus.bus_rdata = '0; bus.bus_ack = 1'b0;
      #12;
      check("rst_data", mem_data, 0);
      check("rst_rwe", {31'b0, mem_reg_we}, 0);
      check("rst_hi", mem_hi, 0);
      check("rst_req", {31'b0, bus.bus_req}, 0);
      check("rst_stall", {31'b0, stall_req}, 0);
      check("rst_sel", {28'b0, bus.bus_sel}, 0);
      @(negedge clk); rst = 1'b1;

      // ALU op passes straight through.
      @(posedge clk); #1;
      ex_data = 32'h55; ex_waddr = 5'd3; ex_hi_we = 1'b1;
      #1;
      check("add_data", mem_data, 32'h55);
      check("add_waddr", {27'b0, mem_waddr}, 3);
      check("add_hi_we", {31'b0, mem_hi_we}, 1);
      check("add_rwe", {31'b0, mem_reg_we}, 1);
      check("add_stall", {31'b0, stall_req}, 0);
      ex_mem_op = 4'd12;
      #1 check("op12_stall", {31'b0, stall_req}, 0);
      @(negedge clk) check("op12_req", {31'b0, bus.bus_req}, 0);
      @(posedge clk); #1 ex_mem_op = 4'd0;

      run_op(4'd1, 32'h1003, 0, 32'h80FF_FF00, 2,
             mk(0, 32'h1000, 4'b1000, 0, 32'hFFFF_FF80, 1, 4));
      run_op(4'd4, 32'h2002, 0, 32'hBEEF_1234, 0,
             mk(0, 32'h2000, 4'b1100, 0, 32'h0000_BEEF, 1, 2));
      run_op(4'd7, 32'h3002, 32'h1234_ABCD, 0, 1,
             mk(1, 32'h3000, 4'b1100, 32'hABCD_ABCD, EXD, 0, 3));
      run_op(4'd6, 32'h3101, 32'h0000_00A7, 0, 0,
             mk(1, 32'h3100, 4'b0010, 32'hA7A7_A7A7, EXD, 0, 2));
      run_op(4'd8, 32'h3204, 32'h0BAD_F00D, 0, 0,
             mk(1, 32'h3204, 4'b1111, 32'h0BAD_F00D, EXD, 0, 2));
      run_op(4'd3, 32'h3302, 0, 32'h8001_7FFF, 0,
             mk(0, 32'h3300, 4'b1100, 0, 32'hFFFF_8001, 1, 2));

      // Misaligned word load: error pulse, no bus traffic.
      @(posedge clk); #1;
      ex_mem_op = 4'd5; ex_mem_addr = 32'h4001;
      #1;
      check("mis_err", {31'b0, align_err}, 1);
      check("mis_stall", {31'b0, stall_req}, 0);
      check("mis_rwe", {31'b0, mem_reg_we}, 0);
      @(negedge clk) check("mis_req", {31'b0, bus.bus_req}, 0);
      @(posedge clk); #1 ex_mem_op = 4'd0;
      #1 check("mis_err_clr", {31'b0, align_err}, 0);
      @(negedge clk) check("mis_req2", {31'b0, bus.bus_req}, 0);

      for (int i = 0; i < 8; i++) begin
         op = 4'($urandom_range(1, 5));
         a  = {16'h0, 4'h6, 4'(i), 6'($urandom), 2'b00};
         if (op == 4'd1 || op == 4'd2) a[1:0] = 2'($urandom);
         if (op == 4'd3 || op == 4'd4) a[1] = 1'($urandom);
         rd = $urandom;
         dl = $urandom_range(0, 2);
         run_op(op, a, 0, rd, dl,
                mk(0, {a[31:2], 2'b00}, sel_ref(op, a[1:0]), 0,
                   ld_ref(op, a[1:0], rd), 1, 2 + dl));
      end

      // Reset in the middle of a bus cycle.
      @(posedge clk); #1;
      ex_mem_op = 4'd5; ex_mem_addr = 32'h5000;
      @(negedge clk);
      @(negedge clk) check("rb_req", {31'b0, bus.bus_req}, 1);
      #1 rst = 1'b0;
      #1;
      check("rb_req0", {31'b0, bus.bus_req}, 0);
      check("rb_stall", {31'b0, stall_req}, 0);
      check("rb_addr", bus.bus_addr, 0);
      check("rb_data", mem_data, 0);
      ex_mem_op = 4'd0; bus.bus_ack = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rb_ack_req", {31'b0, bus.bus_req}, 0);
      check("rb_ack_stall", {31'b0, stall_req}, 0);
      bus.bus_ack = 1'b0;

      run_op(4'd5, 32'h5008, 0, 32'h0123_4567, 0,
             mk(0, 32'h5008, 4'b1111, 0, 32'h0123_4567, 1, 2));
      check("q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  reset; asynchronous, active-low (rst=0 resets).
REQ-003 SHALL have ports: ex_inst in 32, ex_waddr in 5, ex_reg_we in 1, ex_data in 32 (ALU result); destination fields of the instruction in MEM.
REQ-004 SHALL have ports: ex_mem_op in 4, ex_mem_addr in 32, ex_store_data in 32. Op encoding: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
REQ-005 SHALL have ports: ex_hi_we in 1, ex_lo_we in 1, ex_hi in 32, ex_lo in 32; passed through unchanged.
REQ-006 SHALL have ports: mem_inst out 32, mem_waddr out 5, mem_reg_we out 1, mem_data out 32, mem_hi_we out 1, mem_lo_we out 1, mem_hi out 32, mem_lo out 32; feed the MEM/WB register.
REQ-007 SHALL have ports: bus_req out 1, bus_we out 1, bus_addr out 32 (word-aligned), bus_sel out 4 (byte enables, bit0 = addr[1:0]==0), bus_wdata out 32, bus_rdata in 32, bus_ack in 1.
REQ-008 SHALL have ports: stall_req out 1 (holds PC..EX/MEM); align_err out 1 (one-cycle pulse).

Function
REQ-009 SHALL use three states: IDLE, BUSY, DONE.
REQ-010 IDLE, op NONE: mem_* = ex_* combinationally, stall_req=0, bus_req=0.
REQ-011 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; byte ops always aligned.
REQ-012 IDLE, misaligned op: no bus access, mem_reg_we=0, align_err=1 for that cycle, stall_req=0, stay IDLE.
REQ-013 IDLE, aligned memory op: stall_req=1 combinationally same cycle; next edge -> BUSY with bus_req=1 and bus_we, bus_addr={addr[31:2],2'b00}, bus_sel, bus_wdata registered.
REQ-014 bus_sel: byte -> 1<<addr[1:0]; half -> 4'b0011 or 4'b1100 by addr[1]; word -> 4'b1111.
REQ-015 bus_wdata: SB replicates store_data[7:0] into all four lanes; SH replicates [15:0] into both halves; SW passes [31:0].
REQ-016 BUSY: bus_req and all bus_* held stable, stall_req=1, until bus_ack=1 sampled at an edge; then bus_req=0, load result captured, -> DONE. No ack limit.
REQ-017 Load result: selected lane from bus_rdata; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-018 DONE: stall_req=0; loads drive mem_data = captured result, mem_reg_we = ex_reg_we; stores drive mem_reg_we=0; next edge -> IDLE unconditionally (instruction retires into MEM/WB on that edge).
REQ-019 bus_ack while IDLE or DONE SHALL be ignored.
REQ-020 Stores SHALL never assert mem_reg_we; hi/lo outputs SHALL pass through in all states.
REQ-021 Back-to-back memory ops: after DONE->IDLE the new op starts per REQ-013 (min 3 cycles per op with immediate ack).

Reset
REQ-022 rst=0 SHALL immediately force: state IDLE, bus_req=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, captured result=0.
REQ-023 While rst=0 all mem_*, stall_req, align_err SHALL be 0.
REQ-024 Reset during BUSY SHALL abandon the transaction; a later bus_ack SHALL be ignored.

Verification
REQ-025 LB addr=0x1003, bus_rdata=0x80FF_FF00, ack 2 cycles after req -> bus_sel=4'b1000, mem_data=0xFFFF_FF80, stall_req high 4 cycles.
REQ-026 LHU addr=0x2002, rdata=0xBEEF_1234, immediate ack -> bus_sel=4'b1100, mem_data=0x0000_BEEF, mem_reg_we=1 in DONE.
REQ-027 SH addr=0x3002, store_data=0x1234_ABCD -> bus_we=1, bus_sel=4'b1100, bus_wdata=0xABCD_ABCD, mem_reg_we=0.
REQ-028 LW addr=0x4001 -> align_err one cycle, bus_req never asserts, mem_reg_we=0, stall_req=0.
REQ-029 ADD (op NONE) ex_data=0x55, waddr=3, hi_we=1 -> mem_data=0x55, mem_waddr=3, mem_hi_we=1 same cycle, no stall.
REQ-030 rst=0 mid-BUSY, then ack -> bus_req=0 immediately, state IDLE, ack ignored, outputs 0.
